// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-beat memory controller between the data path and a byte-wide synchronous RAM
module memory_controller #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 9
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        DL,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              MOC,
    output logic              align_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

    state_t             state_q, state_d;
    logic               rw_q, rw_d;
    logic [2:0]         nbeats_q, nbeats_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               align_q, align_d;
    logic [31:0]        asm_q, asm_d;
    logic [31:0]        dout_q, dout_d;
    logic [2:0]         beat_q, beat_d;
    logic [3:0]         wait_q, wait_d;

    // A beat is in progress while ACCESS has not yet consumed every beat; the
    // cycle after the last beat is a settle cycle with the RAM idle, during
    // which the assembled word is handed to data_out.
    logic       in_beat;
    logic [1:0] byte_sel;

    assign in_beat  = (state_q == ACCESS) && (beat_q != nbeats_q);
    assign byte_sel = 2'(nbeats_q - beat_q - 3'd1);

    // Next-state logic: request capture, beat/wait sequencing and read assembly
    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        nbeats_d = nbeats_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        align_d  = align_q;
        asm_d    = asm_q;
        dout_d   = dout_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    rw_d    = RW;
                    wdata_d = data_in;
                    asm_d   = '0;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = ACCESS;
                    case (DL)
                        2'b00: begin
                            nbeats_d = 3'd1;
                            base_d   = address;
                            align_d  = 1'b0;
                        end
                        2'b01: begin
                            nbeats_d = 3'd2;
                            base_d   = {address[ADDR_W-1:1], 1'b0};
                            align_d  = address[0];
                        end
                        default: begin
                            nbeats_d = 3'd4;
                            base_d   = {address[ADDR_W-1:2], 2'b00};
                            align_d  = |address[1:0];
                        end
                    endcase
                end
            end
            ACCESS: begin
                if (in_beat) begin
                    if (wait_q == WS_LAST) begin
                        wait_d = '0;
                        beat_d = beat_q + 3'd1;
                        if (rw_q) begin
                            asm_d = {asm_q[23:0], mem_rdata};
                        end
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end else begin
                    state_d = DONE;
                    if (rw_q) begin
                        dout_d = asm_q;
                    end
                end
            end
            DONE: begin
                if (!MOV) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rw_q     <= 1'b0;
            nbeats_q <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            align_q  <= 1'b0;
            asm_q    <= '0;
            dout_q   <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            nbeats_q <= nbeats_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            align_q  <= align_d;
            asm_q    <= asm_d;
            dout_q   <= dout_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
        end
    end

    // Outputs decode from registered state only, so reset drops them at once
    assign data_out  = dout_q;
    assign MOC       = (state_q == DONE);
    assign align_err = (state_q == DONE) && align_q;
    assign mem_en    = in_beat;
    assign mem_we    = in_beat && !rw_q;
    assign mem_addr  = in_beat ? (base_q + ADDR_W'(beat_q)) : '0;
    assign mem_wdata = (in_beat && !rw_q) ? wdata_q[8*byte_sel +: 8] : 8'h00;

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - self-checking bench for memory_controller
module tb_memory_controller;

    localparam int WS = 1;
    localparam int AW = 9;

    logic          main_clk = 1'b0;
    logic          reset    = 1'b0;
    logic          MOV      = 1'b0;
    logic          RW       = 1'b0;
    logic [1:0]    DL       = 2'b00;
    logic [AW-1:0] address  = '0;
    logic [31:0]   data_in  = '0;
    logic [31:0]   data_out;
    logic          MOC;
    logic          align_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    memory_controller #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
        .main_clk (main_clk),
        .reset    (reset),
        .MOV      (MOV),
        .RW       (RW),
        .DL       (DL),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .MOC      (MOC),
        .align_err(align_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 main_clk = ~main_clk;

    // Byte-wide RAM with a bench-side preload port
    logic [7:0]    ram [512];
    logic          poke_en   = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [7:0]    poke_data = '0;

    assign mem_rdata = ram[mem_addr];

    always @(posedge main_clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end

    // Beat monitor: one entry per cycle the RAM is enabled
    typedef struct packed {
        logic [AW-1:0] a;
        logic          we;
        logic [7:0]    d;
    } beat_t;

    beat_t seen [$];

    always @(negedge main_clk) begin
        if (mem_en === 1'b1) seen.push_back({mem_addr, mem_we, mem_we ? mem_wdata : 8'h00});
    end

    // Reference model state
    logic [7:0]  gold [512];
    logic [31:0] model_dout = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] v);
        @(negedge main_clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = v;
        gold[a]   = v;
        @(negedge main_clk);
        poke_en   = 1'b0;
    endtask

    // One request: model computes the beat list, latency, alignment flag and
    // read result straight from the request fields and the golden memory.
    task automatic run(input logic rw, input logic [1:0] dl, input logic [AW-1:0] a,
                       input logic [31:0] d, input int hold, input string tag);
        int            n;
        int            lat;
        int            start;
        int            err;
        logic [AW-1:0] base;
        logic          exp_al;
        logic [31:0]   rd;
        beat_t         exp_q [$];

        n      = (dl == 2'b00) ? 1 : (dl == 2'b01) ? 2 : 4;
        base   = a & ~AW'(n - 1);
        exp_al = ((a % n) != 0);
        rd     = '0;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w <= WS; w++)
                exp_q.push_back({base + AW'(i), !rw, rw ? 8'h00 : d[8*(n-1-i) +: 8]});
        end
        if (rw) begin
            for (int i = 0; i < n; i++) rd = (rd << 8) | 32'(gold[base + AW'(i)]);
            model_dout = rd;
        end else begin
            for (int i = 0; i < n; i++) gold[base + AW'(i)] = d[8*(n-1-i) +: 8];
        end

        @(negedge main_clk);
        start   = seen.size();
        MOV     = 1'b1;
        RW      = rw;
        DL      = dl;
        address = a;
        data_in = d;
        lat     = 0;
        do begin
            @(posedge main_clk);
            lat++;
            @(negedge main_clk);
        end while (MOC !== 1'b1 && lat < 200);
        #1;
        check({tag, "_latency"}, 32'(lat - 1), 32'(1 + n * (WS + 1)));
        check({tag, "_align"}, 32'(align_err), 32'(exp_al));
        check({tag, "_data_out"}, data_out, model_dout);
        check({tag, "_trace_len"}, 32'(seen.size() - start), 32'(exp_q.size()));
        err = 0;
        for (int i = 0; i < exp_q.size() && start + i < seen.size(); i++)
            if (seen[start + i] !== exp_q[i]) err++;
        check({tag, "_trace_beats"}, 32'(err), 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(negedge main_clk);
            check({tag, "_hold_moc_en"}, 32'({MOC, mem_en}), 32'b10);
        end
        if (hold > 0) check({tag, "_hold_no_restart"}, 32'(seen.size() - start), 32'(exp_q.size()));

        @(negedge main_clk);
        MOV = 1'b0;
        @(negedge main_clk);
        check({tag, "_moc_drop"}, 32'({MOC, align_err}), 32'd0);
    endtask

    initial begin
        int start;
        int t;

        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        for (int i = 0; i < 512; i++) gold[i] = 8'h00;

        // Reset state
        #3;
        check("rst_moc", 32'(MOC), 32'd0);
        check("rst_align", 32'(align_err), 32'd0);
        check("rst_en_we", 32'({mem_en, mem_we}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        @(negedge main_clk);
        reset = 1'b1;

        for (int i = 0; i < 512; i++) poke(AW'(i), 8'($urandom));
        poke(9'h010, 8'hDE);
        poke(9'h011, 8'hAD);
        poke(9'h012, 8'hBE);
        poke(9'h013, 8'hEF);
        poke(9'h020, 8'h12);
        poke(9'h021, 8'h34);

        run(1'b1, 2'b10, 9'h010, 32'h0, 0, "word_rd");
        check("word_rd_const", data_out, 32'hDEADBEEF);

        run(1'b0, 2'b00, 9'h007, 32'h000000A5, 0, "byte_wr");
        check("byte_wr_keeps_dout", data_out, 32'hDEADBEEF);

        run(1'b1, 2'b01, 9'h021, 32'h0, 0, "half_rd_mis");
        check("half_rd_const", data_out, 32'h00001234);

        run(1'b0, 2'b10, 9'h1FE, 32'h11223344, 0, "word_wr_top");
        run(1'b1, 2'b10, 9'h1FC, 32'h0, 0, "word_rd_top");
        check("word_rd_top_const", data_out, 32'h11223344);
        run(1'b0, 2'b00, 9'h1FF, 32'h0000005A, 0, "byte_wr_top");
        run(1'b1, 2'b11, 9'h1FF, 32'h0, 0, "dl3_rd_top");
        check("dl3_rd_top_const", data_out, 32'h1122335A);

        run(1'b1, 2'b00, 9'h100, 32'h0, 5, "hold");

        // Reset in the middle of beat 2 of a word write
        @(negedge main_clk);
        start   = seen.size();
        MOV     = 1'b1;
        RW      = 1'b0;
        DL      = 2'b10;
        address = 9'h040;
        data_in = 32'hCAFEF00D;
        t       = 0;
        do begin
            @(negedge main_clk);
            #1;
            t++;
        end while (!(seen.size() > start && seen[seen.size() - 1].a == 9'h041) && t < 50);
        check("abort_reached_beat2", 32'(t < 50), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_en_we_moc", 32'({mem_en, mem_we, MOC}), 32'd0);
        gold[9'h040] = 8'hCA;
        model_dout   = '0;
        MOV          = 1'b0;
        @(negedge main_clk);
        reset = 1'b1;
        check("abort_data_out_cleared", data_out, 32'd0);
        run(1'b1, 2'b00, 9'h040, 32'h0, 0, "post_rst_rd0");
        run(1'b1, 2'b00, 9'h041, 32'h0, 0, "post_rst_rd1");

        // Randomized requests against the golden memory
        for (int k = 0; k < 24; k++) begin
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 511)),
                $urandom, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
